mdu_seq: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the single-cycle ALU. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, models fixed per-class latency with a down-counter and a `busy` flag the hazard unit uses to stall MFHI/MFLO and further MDU ops. Supports flush for a cancelled (exception/interrupt) instruction without corrupting HI/LO.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_calc.sv | 86 ++++++++
 rtl/mdu_seq.sv | 159 +++++++++++++++
 tb/tb_mdu_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// op encodings, FSM state type and default latency constants.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic [0:0] {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 32'd5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 32'd10;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic mdu_is_long(input mdu_op_e op);
        logic r;
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator for the MDU: produces the full
// {HI, LO} pair for multiply and divide, including the divide-by-zero
// and most-negative / -1 overflow rules.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
)
(
    input  mdu_op_e              op,
    input  logic [WIDTH-1:0]     s1,
    input  logic [WIDTH-1:0]     s2,
    output logic [2*WIDTH-1:0]   res
);

    localparam int unsigned   W2      = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

    logic             signed_s;
    logic [W2-1:0]    a_ext_s;
    logic [W2-1:0]    b_ext_s;
    logic [W2-1:0]    prod_s;
    logic             neg_a_s;
    logic             neg_b_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] div_s;
    logic [WIDTH-1:0] q_mag_s;
    logic [WIDTH-1:0] r_mag_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;
    logic             div_zero_s;
    logic             div_ovf_s;

    // Operand conditioning, product and magnitude-based divide.
    always_comb begin
        signed_s = (op == MDU_MULT) || (op == MDU_DIV);

        // Sign/zero extension to 2*WIDTH makes the truncated product exact.
        a_ext_s = {{WIDTH{signed_s & s1[WIDTH-1]}}, s1};
        b_ext_s = {{WIDTH{signed_s & s2[WIDTH-1]}}, s2};
        prod_s  = a_ext_s * b_ext_s;

        neg_a_s = signed_s & s1[WIDTH-1];
        neg_b_s = signed_s & s2[WIDTH-1];
        a_mag_s = neg_a_s ? -s1 : s1;
        b_mag_s = neg_b_s ? -s2 : s2;

        // Guard the divider against a zero divisor; that case is overridden below.
        div_zero_s = (s2 == ZERO_W);
        div_s      = div_zero_s ? ONE_W : b_mag_s;
        q_mag_s    = a_mag_s / div_s;
        r_mag_s    = a_mag_s % div_s;

        quo_s = (neg_a_s ^ neg_b_s) ? -q_mag_s : q_mag_s;
        rem_s = neg_a_s ? -r_mag_s : r_mag_s;

        div_ovf_s = (op == MDU_DIV) && (s1 == MIN_W) && (s2 == ONES_W);
    end

    // Select the {HI, LO} result for the requested op.
    always_comb begin
        res = {ZERO_W, ZERO_W};
        case (op)
            MDU_MULT, MDU_MULTU: begin
                res = prod_s;
            end
            MDU_DIV, MDU_DIVU: begin
                if (div_zero_s) begin
                    res = {s1, ONES_W};
                end else if (div_ovf_s) begin
                    res = {ZERO_W, MIN_W};
                end else begin
                    res = {rem_s, quo_s};
                end
            end
            default: begin
                res = {ZERO_W, ZERO_W};
            end
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with architectural HI/LO.
// The result is computed at issue into a shadow pair and only copied
// to HI/LO when the latency counter expires, so a flush or reset
// during the busy window leaves HI/LO untouched (or cleared by reset).
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] s1,
    input  logic [WIDTH-1:0] s2,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned   MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned   CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    mdu_op_e          op_s;
    logic             accept_s;
    logic             mthi_s;
    logic             mtlo_s;
    logic             is_div_s;
    logic [2*WIDTH-1:0] calc_res_s;

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    mdu_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op  (op_s),
        .s1  (s1),
        .s2  (s2),
        .res (calc_res_s)
    );

    // Decode the issue request; flush cancels anything issued alongside it.
    always_comb begin
        op_s     = mdu_op_e'(op);
        is_div_s = (op_s == MDU_DIV) || (op_s == MDU_DIVU);
        accept_s = (state_q == MDU_IDLE) && start && !flush && mdu_is_long(op_s);
        mthi_s   = (state_q == MDU_IDLE) && start && !flush && (op_s == MDU_MTHI);
        mtlo_s   = (state_q == MDU_IDLE) && start && !flush && (op_s == MDU_MTLO);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: leave RUN on flush or when the counter is about to expire.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: begin
                if (accept_s) begin
                    state_d = MDU_RUN;
                end else begin
                    state_d = MDU_IDLE;
                end
            end
            MDU_RUN: begin
                if (flush) begin
                    state_d = MDU_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = MDU_IDLE;
                end else begin
                    state_d = MDU_RUN;
                end
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
    end

    // FSM outputs: busy is a pure decode of the state register.
    always_comb begin
        busy = (state_q == MDU_RUN);
    end

    // Datapath next-state: counter, shadow result and architectural HI/LO.
    always_comb begin
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (flush) begin
            cnt_d    = CNT_ZERO;
            res_hi_d = ZERO_W;
            res_lo_d = ZERO_W;
        end else if (state_q == MDU_IDLE) begin
            if (accept_s) begin
                res_hi_d = calc_res_s[2*WIDTH-1:WIDTH];
                res_lo_d = calc_res_s[WIDTH-1:0];
                cnt_d    = is_div_s ? DIV_LD : MULT_LD;
            end else if (mthi_s) begin
                hi_d = s1;
            end else if (mtlo_s) begin
                lo_d = s1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                hi_d = res_hi_q;
                lo_d = res_lo_q;
            end else begin
                hi_d = hi_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= CNT_ZERO;
            res_hi_q <= ZERO_W;
            res_lo_q <= ZERO_W;
            hi_q     <= ZERO_W;
            lo_q     <= ZERO_W;
        end else begin
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus pushes the expected HI/LO and
// busy length of each long op; a monitor pops and compares when busy falls.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] s1    = 32'd0;
    logic [31:0] s2    = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   next_id  = 0;

    mdu_seq #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .s1    (s1),
        .s2    (s2),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] e_hi, input logic [31:0] e_lo, input int cyc);
        exp_t e;
        e.hi  = e_hi;
        e.lo  = e_lo;
        e.cyc = cyc;
        e.id  = next_id;
        next_id++;
        exp_q.push_back(e);
    endtask

    // Called at a negedge: holds start for one rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        s1    = a;
        s2    = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
    endtask

    task automatic issue_chk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] e_hi, input logic [31:0] e_lo, input int cyc);
        push_exp(e_hi, e_lo, cyc);
        issue(o, a, b);
    endtask

    // Returns at the first negedge with busy low, bounded.
    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: busy still high after 40 cycles");
        end
    endtask

    // Monitor: counts busy cycles and checks the result when busy falls.
    initial begin
        int   bcnt;
        logic prev_busy;
        exp_t e;
        bcnt      = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                bcnt      = 0;
            end else if (busy) begin
                bcnt++;
                prev_busy = 1'b1;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion: got hi=0x%08h lo=0x%08h expected no op", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("op%0d_hi", e.id), hi, e.hi);
                    chk($sformatf("op%0d_lo", e.id), lo, e.lo);
                    chk($sformatf("op%0d_busy_cycles", e.id), 32'(bcnt), 32'(e.cyc));
                end
                prev_busy = 1'b0;
                bcnt      = 0;
            end
        end
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiply / divide vectors, issued back-to-back
        issue_chk(MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 5);  wait_idle();
        issue_chk(MDU_MULTU, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB, 5);  wait_idle();
        issue_chk(MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5);  wait_idle();
        issue_chk(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);  wait_idle();
        issue_chk(MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10); wait_idle();
        issue_chk(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10); wait_idle();
        issue_chk(MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10); wait_idle();
        issue_chk(MDU_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 10); wait_idle();
        issue_chk(MDU_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 10); wait_idle();
        issue_chk(MDU_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10); wait_idle();
        issue_chk(MDU_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 10); wait_idle();

        // MTHI / MTLO in idle: one-cycle latency, no busy
        start = 1'b1; op = MDU_MTHI; s1 = 32'h11111111;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h11111111);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        op = MDU_MTLO;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        chk("mtlo_lo", lo, 32'h11111111);

        // Flush on 3rd busy cycle together with a MULT start
        push_exp(32'h11111111, 32'h11111111, 3);
        issue(MDU_DIV, 32'h00000064, 32'h00000007);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; s1 = 32'd3; s2 = 32'd3; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'd0; flush = 1'b0;
        chk("flush_busy_low", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("flush_mult_rejected", {31'd0, busy}, 32'd0);
        chk("flush_hi_kept", hi, 32'h11111111);
        chk("flush_lo_kept", lo, 32'h11111111);

        // MTHI and a second start while busy are both ignored
        issue_chk(MDU_MULT, 32'd3, 32'd5, 32'h00000000, 32'h0000000F, 5);
        start = 1'b1; op = MDU_MTHI; s1 = 32'hA5A5A5A5;
        @(negedge clk);
        chk("mthi_busy_ignored", hi, 32'h11111111);
        op = MDU_DIV; s1 = 32'd100; s2 = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        wait_idle();
        @(negedge clk);
        chk("run_start_ignored", {31'd0, busy}, 32'd0);

        // MTHI in idle
        start = 1'b1; op = MDU_MTHI; s1 = 32'hA5A5A5A5;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        chk("mthi_idle_hi", hi, 32'hA5A5A5A5);
        chk("mthi_idle_busy", {31'd0, busy}, 32'd0);
        chk("mthi_idle_lo", lo, 32'h0000000F);

        // Asynchronous reset in the middle of a DIV
        issue(MDU_DIV, 32'd100, 32'd3);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_busy", {31'd0, busy}, 32'd0);
        chk("midrun_reset_hi", hi, 32'd0);
        chk("midrun_reset_lo", lo, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        issue_chk(MDU_MULT, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 5);
        wait_idle();

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
